// File: rtl/tx_interface.sv
// -----------------------------------------------------------------------------
// tx_interface
//
// Transmit-side companion of the calculator receive path. Every ALU result byte
// announced by a one-cycle i_data_ready pulse is queued in a small circular
// FIFO. A small FSM then feeds the bytes, one at a time, to the UART TX core
// using a start/done handshake.
//
// Configuration macro:
//   TX_IFACE_NEWLINE_EN - when defined, every result byte is followed by a
//                         newline byte (8'h0A). Each result then costs two
//                         TX handshakes. When undefined, exactly one byte is
//                         sent per result.
//
// Parameters:
//   NB_DATA  width of the result byte and of the TX data (default 8)
//   NB_ADDR  FIFO address width, depth = 2**NB_ADDR (default 2 -> 4 entries)
//
// Ports:
//   i_clk         in   system clock, rising edge
//   i_reset       in   asynchronous active-high reset
//   i_data_ready  in   one-cycle pulse, i_data is a result to queue
//   i_data        in   result byte
//   i_tx_done     in   UART TX finished the current byte (pulse or level)
//   o_tx_start    out  one-cycle pulse asking UART TX to send o_tx_data
//   o_tx_data     out  byte to transmit (registered)
//   o_empty       out  FIFO empty
//   o_full        out  FIFO holds 2**NB_ADDR entries
//   o_overflow    out  sticky: a push was dropped (cleared only by reset)
// -----------------------------------------------------------------------------
module tx_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_data_ready,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_overflow
);

  localparam int DEPTH = 1 << NB_ADDR;

  // Count constants, NB_ADDR+1 bits wide so that "full" (== DEPTH) fits.
  localparam logic [NB_ADDR:0]   CNT_ZERO  = {(NB_ADDR+1){1'b0}};
  localparam logic [NB_ADDR:0]   CNT_ONE   = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   CNT_DEPTH = {1'b1, {NB_ADDR{1'b0}}};
  localparam logic [NB_ADDR-1:0] PTR_ONE   = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_DATA-1:0] DATA_ZERO = {NB_DATA{1'b0}};

  // FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
`ifdef TX_IFACE_NEWLINE_EN
  localparam logic [2:0] ST_NL_SEND = 3'd3;
  localparam logic [2:0] ST_NL_WAIT = 3'd4;
  localparam logic [NB_DATA-1:0] NEWLINE = NB_DATA'(8'h0A);
`endif

  // FIFO storage and bookkeeping
  logic [NB_DATA-1:0] mem_r [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr_r;
  logic [NB_ADDR-1:0] rd_ptr_r;
  logic [NB_ADDR:0]   count_r;
  logic [NB_ADDR:0]   count_next_s;

  // Handshake qualifiers
  logic push_s;
  logic pop_s;
  logic drop_s;

  // FSM and registered outputs
  logic [2:0]         state_r;
  logic [2:0]         state_next_s;
  logic               tx_start_r;
  logic               tx_start_next_s;
  logic [NB_DATA-1:0] tx_data_r;
  logic [NB_DATA-1:0] tx_data_next_s;
  logic               empty_r;
  logic               full_r;
  logic               overflow_r;

  // Pop/push qualification: the FSM pops the head only from IDLE; a push into
  // a full FIFO is still accepted when a pop frees a slot on the same edge.
  always_comb begin
    pop_s  = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
    push_s = i_data_ready && ((count_r != CNT_DEPTH) || pop_s);
    drop_s = i_data_ready && !push_s;
  end

  // Next occupancy count from the push/pop pair of this edge.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers, count, status flags and the sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_r   <= {NB_ADDR{1'b0}};
      rd_ptr_r   <= {NB_ADDR{1'b0}};
      count_r    <= CNT_ZERO;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      // Pointers wrap naturally modulo the depth.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      // Flags track the count that becomes current on this edge.
      empty_r    <= (count_next_s == CNT_ZERO);
      full_r     <= (count_next_s == CNT_DEPTH);
      overflow_r <= overflow_r | drop_s;
    end
  end

  // FSM next-state, start strobe and TX data selection.
  always_comb begin
    state_next_s    = state_r;
    tx_start_next_s = 1'b0;
    tx_data_next_s  = tx_data_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          // Strobe is raised on entry into SEND so it is high while in SEND.
          state_next_s    = ST_SEND;
          tx_start_next_s = 1'b1;
          tx_data_next_s  = mem_r[rd_ptr_r];
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef TX_IFACE_NEWLINE_EN
          state_next_s   = ST_NL_SEND;
          tx_data_next_s = NEWLINE;
`else
          state_next_s = ST_IDLE;
`endif
        end else begin
          state_next_s = ST_WAIT;
        end
      end
`ifdef TX_IFACE_NEWLINE_EN
      ST_NL_SEND: begin
        // The newline byte is already on o_tx_data; the strobe follows one
        // cycle later so the data has settled a full cycle before the start.
        state_next_s    = ST_NL_WAIT;
        tx_start_next_s = 1'b1;
      end
      ST_NL_WAIT: begin
        if (i_tx_done) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_NL_WAIT;
        end
      end
`endif
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered TX outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= DATA_ZERO;
    end else begin
      state_r    <= state_next_s;
      tx_start_r <= tx_start_next_s;
      tx_data_r  <= tx_data_next_s;
    end
  end

  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;
  assign o_empty    = empty_r;
  assign o_full     = full_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_tx_interface.sv
// -----------------------------------------------------------------------------
// tb_tx_interface
//
// Scoreboard bench for tx_interface. Stimulus pushes the expected transmit
// bytes into exp_q as results are issued; a monitor pops and compares each
// time the DUT raises o_tx_start. A responder answers starts with i_tx_done
// after a programmable delay (or on explicit request from the stimulus).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_interface;

  localparam int NB_DATA = 8;
  localparam int NB_ADDR = 2;
`ifdef TX_IFACE_NEWLINE_EN
  localparam int PER_RESULT = 2;
`else
  localparam int PER_RESULT = 1;
`endif

  logic               clk;
  logic               i_reset;
  logic               i_data_ready;
  logic [NB_DATA-1:0] i_data;
  logic               i_tx_done;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_empty;
  logic               o_full;
  logic               o_overflow;

  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   done_delay = 3;
  int   kick_req = 0;
  bit   done_en = 1'b0;
  logic [7:0] exp_q[$];

  tx_interface #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_data_ready (i_data_ready),
    .i_data       (i_data),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected transmit sequence for one result byte.
  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
`ifdef TX_IFACE_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_data_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    i_data_ready = 1'b1;
    i_data = b;
    @(negedge clk);
    i_data_ready = 1'b0;
  endtask

  // Wait (bounded) until every expected byte went out and the FIFO is empty.
  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !o_empty) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
    check("drain_in_time", (t < 3000), 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Monitor: every start strobe must match the head of the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!i_reset && o_tx_start) begin
        starts++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got data %0h, expected no start", o_tx_data);
        end else begin
          b = exp_q.pop_front();
          check("tx_data", o_tx_data, b);
        end
      end
    end
  end

  // Responder: answers starts with a one-cycle i_tx_done, or on request.
  initial begin : responder
    int served;
    served = 0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (kick_req != served) begin
        served++;
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
      end else if (done_en && o_tx_start && !i_reset) begin
        repeat (done_delay) @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s0;
    i_reset = 1'b1;
    i_data_ready = 1'b0;
    i_data = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_overflow", o_overflow, 0);
    i_reset = 1'b0;

    // Single result 8'h2A: start two edges after the push edge
    done_en = 1'b1;
    done_delay = 3;
    s0 = starts;
    @(negedge clk);
    i_data_ready = 1'b1;
    i_data = 8'h2A;
    push_exp(8'h2A);
    @(negedge clk);
    i_data_ready = 1'b0;
    check("single_not_empty", o_empty, 0);
    check("single_no_early_start", o_tx_start, 0);
    @(negedge clk);
    check("single_start_latency", o_tx_start, 1);
    check("single_data", o_tx_data, 8'h2A);
    wait_drain();
    check("single_empty_after", o_empty, 1);
    check("single_start_count", starts - s0, PER_RESULT);

`ifdef TX_IFACE_NEWLINE_EN
    // Newline: 8'h05 then 8'h0A, done answered 10 cycles after each start
    done_delay = 10;
    s0 = starts;
    push_one(8'h05);
    push_exp(8'h05);
    wait_drain();
    check("nl_start_count", starts - s0, 2);
    done_delay = 3;
`endif

    // Fill and overflow: 01 in flight, 02..05 fill the FIFO, 06 dropped
    do_reset();
    done_en = 1'b0;
    s0 = starts;
    for (int b = 1; b <= 6; b++) begin
      @(negedge clk);
      i_data_ready = 1'b1;
      i_data = 8'(b);
      if (b <= 5) push_exp(8'(b));
    end
    @(negedge clk);
    i_data_ready = 1'b0;
    check("fill_full", o_full, 1);
    check("fill_overflow", o_overflow, 1);
    check("fill_not_empty", o_empty, 0);
    @(posedge clk);
    #1 kick_req++;
    done_en = 1'b1;
    wait_drain();
    check("fill_start_count", starts - s0, 5 * PER_RESULT);
    check("fill_overflow_sticky", o_overflow, 1);
    check("fill_full_cleared", o_full, 0);

`ifndef TX_IFACE_NEWLINE_EN
    // Simultaneous push/pop while full: 8'h77 pushed on the pop edge
    do_reset();
    done_en = 1'b0;
    s0 = starts;
    for (int b = 1; b <= 5; b++) begin
      @(negedge clk);
      i_data_ready = 1'b1;
      i_data = 8'(b);
      push_exp(8'(b));
    end
    @(negedge clk);
    i_data_ready = 1'b0;
    check("pp_full_before", o_full, 1);
    push_exp(8'h77);
    @(posedge clk);
    #1 kick_req++;
    @(negedge clk);            // i_tx_done driven high here
    @(negedge clk);            // done sampled, FSM back in IDLE
    i_data_ready = 1'b1;
    i_data = 8'h77;
    done_en = 1'b1;
    @(negedge clk);            // pop and push on the same edge
    i_data_ready = 1'b0;
    check("pp_full_after", o_full, 1);
    check("pp_no_overflow", o_overflow, 0);
    wait_drain();
    check("pp_start_count", starts - s0, 6);
`endif

    // Wrap-around: ten single results, pointers wrap twice
    do_reset();
    done_en = 1'b1;
    done_delay = 2;
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      push_exp(8'h10 + 8'(i));
      push_one(8'h10 + 8'(i));
      wait_drain();
    end
    check("wrap_start_count", starts - s0, 10 * PER_RESULT);
    check("wrap_no_overflow", o_overflow, 0);

    // Reset during WAIT with two bytes queued
    do_reset();
    done_en = 1'b0;
    push_exp(8'hA1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      i_data_ready = 1'b1;
      i_data = 8'hA1 + 8'(b);
    end
    @(negedge clk);
    i_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_not_empty", o_empty, 0);
    s0 = starts;
    i_reset = 1'b1;
    #1;
    check("mid_rst_tx_start", o_tx_start, 0);
    check("mid_rst_tx_data", o_tx_data, 0);
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_full", o_full, 0);
    check("mid_rst_overflow", o_overflow, 0);
    exp_q.delete();
    @(negedge clk);
    i_reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_no_start_after", starts - s0, 0);
    check("mid_empty_after", o_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
